id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Decode/operand-fetch stage that sits between the IF/ID register and the EX stage, directly upstream of the register file's read ports.
- Drives the regfile read addresses from the IF/ID instruction and captures the returned operands.
- Decodes a MIPS subset and registers the ID/EX pipeline fields.
- Detects load-use hazards, inserts bubbles, and honours flush and downstream hold.
- Keeps a saturating bubble counter for performance debug.

Parameters:
DATA_W, 32, width of PC, operands and immediate
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-high
if_id_valid  in  1  IF/ID holds a real instruction
if_id_instr  in  32  instruction word
if_id_pc  in  DATA_W  PC+4 of the instruction
src1  out  5  regfile read address 1 = instr[25:21]; combinational
src2  out  5  regfile read address 2 = instr[20:16]; combinational
reg1  in  DATA_W  regfile read data 1
reg2  in  DATA_W  regfile read data 2
flush  in  1  taken branch resolved in EX; kill the instruction in ID
hold  in  1  downstream cannot accept; freeze ID/EX
stall_o  out  1  combinational; hold PC and IF/ID this cycle
ex_valid  out  1  ID/EX contents are real
ex_pc  out  DATA_W  registered PC+4
ex_val1, ex_val2  out  DATA_W  registered operands
ex_imm  out  DATA_W  sign-extended instr[15:0]
ex_src1, ex_src2  out  5  registered source addresses, for EX forwarding
ex_dest  out  5  destination register
ex_alu_op  out  4  ALU op code
ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_use_imm  out  1  control bits
ex_illegal  out  1  unsupported opcode or funct
bubble_cnt  out  CNT_W  bubbles inserted by load-use stalls or flushes

Behaviour:
- Reset: all ex_* outputs and bubble_cnt are 0; ex_alu_op = ALU_NOP (4'hF).
- Decode set:
  - R-type (opcode 0) funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT; dest = rd.
  - ADDI 0x08: dest = rt, use_imm, ADD.
  - LW 0x23: dest = rt, mem_read, use_imm, ADD.
  - SW 0x2B: mem_write, use_imm, ADD, no writeback.
  - BEQ 0x04: branch, SUB, no writeback.
- Any other opcode or funct: ex_illegal = 1, wb/mem/branch = 0, ALU_NOP.
- ex_wb_en = writeback instruction AND dest != 0. Writes to $0 never enable writeback.
- Source usage:
  - rs is used by every decoded instruction.
  - rt is used only by R-type, SW and BEQ.
  - ADDI/LW rt is a destination, never a hazard source.
- Load-use hazard: ex_valid AND ex_mem_read AND ex_dest != 0 AND ID instruction valid AND (ex_dest == rs used OR ex_dest == rt used).
- The regfile writes on negedge, so a WB write in cycle N is visible on reg1/reg2 before the closing posedge. No WB-to-ID bypass exists here.
- Per-cycle priority (first match wins):
  1. rst: reset values.
  2. hold: ID/EX unchanged; stall_o = 1; counter unchanged.
  3. flush: load bubble (ex_valid = 0, all enables 0, ALU_NOP); stall_o = 0; count++ if if_id_valid.
  4. load-use: load bubble; stall_o = 1; count++.
  5. normal: capture decode, operands and if_id_valid into ID/EX; stall_o = 0.
- !if_id_valid in the normal case: load a bubble and do not count it.
- Load-use stall lasts exactly 1 cycle. Next cycle the load has left ID/EX, and the dependent instruction issues with the regfile or EX forwarding supplying the value.
- hold overrides flush. The branch unit keeps flush asserted until hold drops.
- bubble_cnt saturates at all-ones; no wrap.
- Latency: 1 cycle from IF/ID to ID/EX.

Decomposition:
- Package id_defs_pkg: opcode and funct constants; ALU op encodings ADD=0, SUB=1, AND=2, OR=3, SLT=4, NOP=F; bubble field values.
- One sub-module, id_decoder: purely combinational instruction word to control bits, dest, rs_used and rt_used.
- Top level holds the hazard logic, the ID/EX register and the counter.

Test Plan:
1. Reset, then valid 0x00221820 (ADD $3,$1,$2) with reg1=5, reg2=7 -> next cycle ex_valid=1, ex_dest=3, ex_val1=5, ex_val2=7, ex_alu_op=0, ex_wb_en=1, stall_o=0.
2. 0x8C250008 (LW $5,8($1)) then 0x00A23020 (ADD $6,$5,$2) -> stall_o=1 for exactly 1 cycle, ID/EX bubble, bubble_cnt=1, then ADD issues with ex_src1=5.
3. 0x2004FFFF (ADDI $4,$0,-1) -> ex_imm=0xFFFFFFFF, ex_use_imm=1, ex_dest=4. Same with rt=0 -> ex_wb_en=0.
4. flush=1 with a valid ADD in ID -> ex_valid=0, stall_o=0, bubble_cnt increments. flush together with a load-use condition -> stall_o=0.
5. hold=1 for 3 cycles with a load-use condition present -> ID/EX frozen, stall_o=1, bubble_cnt unchanged. Release hold -> load-use bubble is inserted.
6. Opcode 0x3F -> ex_illegal=1, no enables. Preload bubble_cnt near max with 2^CNT_W stalls -> counter holds at all-ones. rst mid-stall -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/id_defs_pkg.sv
// id_defs_pkg: shared definitions for the decode / operand-fetch stage.
//   - MIPS opcode and R-type funct constants for the supported subset
//   - ALU op encodings seen by EX
//   - ctrl_t: decoded control bundle carried in the ID/EX register
//   - CTRL_BUBBLE: control field values loaded when ID/EX holds no instruction
package id_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_SLT = 4'h4,
    ALU_NOP = 4'hF
  } alu_op_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       branch;
    logic       use_imm;
    logic       illegal;
    logic [4:0] dest;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{ALU_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};

endpackage

// File: rtl/id_decoder.sv
// id_decoder: purely combinational MIPS-subset decode.
//   instr   in  32  instruction word from IF/ID
//   ctrl    out     control bundle (alu_op, enables, illegal, dest)
//   rs_used out 1   instruction reads rs
//   rt_used out 1   instruction reads rt (R-type, SW, BEQ only)
// Unsupported opcodes/functs raise illegal with every enable low and ALU_NOP;
// they read no sources so they can never trigger a load-use stall.
module id_decoder
  import id_defs_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        rs_used,
  output logic        rt_used
);

  logic [5:0] opcode, funct;
  logic [4:0] rt, rd, dest;
  logic       wb;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];

  // rs is compared at the top level and shamt is not decoded here
  logic unused_bits;
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    wb      = 1'b0;
    dest    = 5'd0;
    rs_used = 1'b0;
    rt_used = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: ctrl.illegal = 1'b1;
        endcase
        if (!ctrl.illegal) begin
          wb      = 1'b1;
          dest    = rd;
          rs_used = 1'b1;
          rt_used = 1'b1;
        end
      end
      OP_ADDI: begin
        ctrl.alu_op  = ALU_ADD;
        ctrl.use_imm = 1'b1;
        wb           = 1'b1;
        dest         = rt;
        rs_used      = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_op   = ALU_ADD;
        ctrl.use_imm  = 1'b1;
        ctrl.mem_read = 1'b1;
        wb            = 1'b1;
        dest          = rt;
        rs_used       = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.use_imm   = 1'b1;
        ctrl.mem_write = 1'b1;
        rs_used        = 1'b1;
        rt_used        = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
        rs_used     = 1'b1;
        rt_used     = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    ctrl.dest  = dest;
    // $0 is hardwired, so a write to it is dropped here rather than in WB
    ctrl.wb_en = wb && (dest != 5'd0);
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode / operand fetch between IF/ID and EX.
//   clk, rst                  clock, synchronous active-high reset
//   if_id_valid/instr/pc      IF/ID contents (pc is PC+4)
//   src1, src2                regfile read addresses (combinational)
//   reg1, reg2                regfile read data
//   flush                     kill the instruction in ID (taken branch)
//   hold                      downstream busy; freeze ID/EX
//   stall_o                   hold PC and IF/ID this cycle
//   ex_*                      registered ID/EX fields
//   bubble_cnt                saturating count of load-use / flush bubbles
// Priority each cycle: rst > hold > flush > load-use > normal issue.
module id_ex_stage
  import id_defs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_id_valid,
  input  logic [31:0]       if_id_instr,
  input  logic [DATA_W-1:0] if_id_pc,
  output logic [4:0]        src1,
  output logic [4:0]        src2,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic              flush,
  input  logic              hold,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_val1,
  output logic [DATA_W-1:0] ex_val2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_src1,
  output logic [4:0]        ex_src2,
  output logic [4:0]        ex_dest,
  output logic [3:0]        ex_alu_op,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_wb_en,
  output logic              ex_branch,
  output logic              ex_use_imm,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  bubble_cnt
);

  ctrl_t dec, ex_ctrl;
  logic  rs_used, rt_used;
  logic  load_use, bubble, count_it;

  id_decoder u_dec (
    .instr   (if_id_instr),
    .ctrl    (dec),
    .rs_used (rs_used),
    .rt_used (rt_used)
  );

  assign src1 = if_id_instr[25:21];
  assign src2 = if_id_instr[20:16];

  // Only loads need a stall; every other producer reaches ID's consumer via
  // EX forwarding or the negedge regfile write.
  assign load_use = ex_valid && ex_ctrl.mem_read && (ex_ctrl.dest != 5'd0) &&
                    if_id_valid &&
                    ((rs_used && (ex_ctrl.dest == src1)) ||
                     (rt_used && (ex_ctrl.dest == src2)));

  // flush discards the dependent instruction, so there is nothing to stall for
  assign stall_o  = hold || (!flush && load_use);
  assign bubble   = flush || load_use || !if_id_valid;
  assign count_it = (flush && if_id_valid) || load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= CTRL_BUBBLE;
      ex_pc      <= '0;
      ex_val1    <= '0;
      ex_val2    <= '0;
      ex_imm     <= '0;
      ex_src1    <= '0;
      ex_src2    <= '0;
      bubble_cnt <= '0;
    end else if (!hold) begin
      if (bubble) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= CTRL_BUBBLE;
        ex_pc    <= '0;
        ex_val1  <= '0;
        ex_val2  <= '0;
        ex_imm   <= '0;
        ex_src1  <= '0;
        ex_src2  <= '0;
      end else begin
        ex_valid <= 1'b1;
        ex_ctrl  <= dec;
        ex_pc    <= if_id_pc;
        ex_val1  <= reg1;
        ex_val2  <= reg2;
        ex_imm   <= {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};
        ex_src1  <= src1;
        ex_src2  <= src2;
      end
      if (count_it && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign ex_dest      = ex_ctrl.dest;
  assign ex_alu_op    = ex_ctrl.alu_op;
  assign ex_mem_read  = ex_ctrl.mem_read;
  assign ex_mem_write = ex_ctrl.mem_write;
  assign ex_wb_en     = ex_ctrl.wb_en;
  assign ex_branch    = ex_ctrl.branch;
  assign ex_use_imm   = ex_ctrl.use_imm;
  assign ex_illegal   = ex_ctrl.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_id_valid = 1'b0;
  logic [31:0]   if_id_instr = '0;
  logic [DW-1:0] if_id_pc = '0, reg1 = '0, reg2 = '0;
  logic          flush = 1'b0, hold = 1'b0;
  logic [4:0]    src1, src2, ex_src1, ex_src2, ex_dest;
  logic          stall_o, ex_valid;
  logic [DW-1:0] ex_pc, ex_val1, ex_val2, ex_imm;
  logic [3:0]    ex_alu_op;
  logic          ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_use_imm, ex_illegal;
  logic [CW-1:0] bubble_cnt;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .src1(src1), .src2(src2), .reg1(reg1), .reg2(reg2),
    .flush(flush), .hold(hold), .stall_o(stall_o), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_imm(ex_imm),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest), .ex_alu_op(ex_alu_op),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en),
    .ex_branch(ex_branch), .ex_use_imm(ex_use_imm), .ex_illegal(ex_illegal),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [4:0]    dest, s1, s2;
    logic [DW-1:0] v1, v2, imm;
    logic [3:0]    op;
    logic          wb, mr, mw, br, ui, ill;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  localparam logic [31:0] I_ADD  = 32'h00221820; // ADD $3,$1,$2
  localparam logic [31:0] I_LW   = 32'h8C250008; // LW $5,8($1)
  localparam logic [31:0] I_DEP  = 32'h00A23020; // ADD $6,$5,$2

  function automatic exp_t bub(input logic [CW-1:0] c);
    exp_t x = '0;
    x.op = 4'hF;
    x.cnt = c;
    return x;
  endfunction

  // expected ID/EX contents after LW $5,8($1) issues at pc 0x200
  function automatic exp_t lw_exp(input logic [CW-1:0] c);
    exp_t x = bub(c);
    x.valid = 1; x.pc = 32'h200; x.dest = 5; x.s1 = 1; x.s2 = 5;
    x.v1 = 32'h1000; x.v2 = 32'h33; x.imm = 32'h8; x.op = 4'h0;
    x.wb = 1; x.mr = 1; x.ui = 1;
    return x;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o.valid = ex_valid; o.pc = ex_pc; o.dest = ex_dest; o.s1 = ex_src1; o.s2 = ex_src2;
    o.v1 = ex_val1; o.v2 = ex_val2; o.imm = ex_imm; o.op = ex_alu_op;
    o.wb = ex_wb_en; o.mr = ex_mem_read; o.mw = ex_mem_write; o.br = ex_branch;
    o.ui = ex_use_imm; o.ill = ex_illegal; o.cnt = bubble_cnt;
    return o;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [DW-1:0] pc, r1, r2,
                       input logic fl, hd, r);
    @(negedge clk);
    rst = r; if_id_valid = v; if_id_instr = ins; if_id_pc = pc;
    reg1 = r1; reg2 = r2; flush = fl; hold = hd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_reset();
    exp_t x, o;
    drive(1, I_ADD, 32'h55, 32'h9, 32'h9, 0, 0, 1);
    sb.push_back(bub(0));
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL reset: got %h want %h", o, x); end
  endtask

  task automatic test_add();
    exp_t x, o;
    do_reset();
    drive(1, I_ADD, 32'h100, 5, 7, 0, 0, 0);
    tests++;
    if (stall_o !== 1'b0) begin fails++; $display("FAIL add_stall: got %b want 0", stall_o); end
    x = bub(0); x.valid = 1; x.pc = 32'h100; x.dest = 3; x.s1 = 1; x.s2 = 2;
    x.v1 = 5; x.v2 = 7; x.imm = 32'h1820; x.op = 0; x.wb = 1;
    sb.push_back(x);
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL add_issue: got %h want %h", o, x); end
  endtask

  task automatic test_load_use();
    exp_t x, o;
    do_reset();
    drive(1, I_LW, 32'h200, 32'h1000, 32'h33, 0, 0, 0);
    sb.push_back(lw_exp(0));
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL lu_load: got %h want %h", o, x); end
    // dependent ADD on rs: one stall cycle with a bubble
    drive(1, I_DEP, 32'h204, 9, 7, 0, 0, 0);
    tests++;
    if (stall_o !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b want 1", stall_o); end
    sb.push_back(bub(1));
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL lu_bubble: got %h want %h", o, x); end
    // same instruction held in IF/ID now issues
    drive(1, I_DEP, 32'h204, 9, 7, 0, 0, 0);
    tests++;
    if (stall_o !== 1'b0) begin fails++; $display("FAIL lu_release: got %b want 0", stall_o); end
    x = bub(1); x.valid = 1; x.pc = 32'h204; x.dest = 6; x.s1 = 5; x.s2 = 2;
    x.v1 = 9; x.v2 = 7; x.imm = 32'h3020; x.op = 0; x.wb = 1;
    sb.push_back(x);
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL lu_issue: got %h want %h", o, x); end
    // ADDI whose rt matches the load dest is not a hazard
    drive(1, I_LW, 32'h200, 32'h1000, 32'h33, 0, 0, 0);
    sb.push_back(lw_exp(1));
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL lu_load2: got %h want %h", o, x); end
    drive(1, 32'h20250001, 32'h208, 4, 8, 0, 0, 0);
    tests++;
    if (stall_o !== 1'b0) begin fails++; $display("FAIL lu_rt_unused: got %b want 0", stall_o); end
    x = bub(1); x.valid = 1; x.pc = 32'h208; x.dest = 5; x.s1 = 1; x.s2 = 5;
    x.v1 = 4; x.v2 = 8; x.imm = 1; x.op = 0; x.wb = 1; x.ui = 1;
    sb.push_back(x);
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL lu_addi: got %h want %h", o, x); end
  endtask

  task automatic test_imm();
    exp_t x, o;
    do_reset();
    drive(1, 32'h2004FFFF, 32'h300, 0, 32'h44, 0, 0, 0);
    x = bub(0); x.valid = 1; x.pc = 32'h300; x.dest = 4; x.s1 = 0; x.s2 = 4;
    x.v1 = 0; x.v2 = 32'h44; x.imm = 32'hFFFFFFFF; x.op = 0; x.wb = 1; x.ui = 1;
    sb.push_back(x);
    x.pc = 32'h304; x.dest = 0; x.s2 = 0; x.wb = 0;   // ADDI $0,$0,-1
    sb.push_back(x);
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL addi_neg: got %h want %h", o, x); end
    drive(1, 32'h2000FFFF, 32'h304, 0, 32'h44, 0, 0, 0);
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL addi_r0: got %h want %h", o, x); end
    // SW $5,4($1)
    drive(1, 32'hAC250004, 32'h308, 32'h10, 32'h20, 0, 0, 0);
    x = bub(0); x.valid = 1; x.pc = 32'h308; x.s1 = 1; x.s2 = 5; x.v1 = 32'h10; x.v2 = 32'h20;
    x.imm = 4; x.op = 0; x.mw = 1; x.ui = 1;
    sb.push_back(x);
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL sw: got %h want %h", o, x); end
    // BEQ $1,$2,-2
    drive(1, 32'h1022FFFE, 32'h30C, 3, 3, 0, 0, 0);
    x = bub(0); x.valid = 1; x.pc = 32'h30C; x.s1 = 1; x.s2 = 2; x.v1 = 3; x.v2 = 3;
    x.imm = 32'hFFFFFFFE; x.op = 1; x.br = 1;
    sb.push_back(x);
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL beq: got %h want %h", o, x); end
  endtask

  task automatic test_flush();
    exp_t x, o;
    do_reset();
    drive(1, I_ADD, 32'h400, 5, 7, 1, 0, 0);
    tests++;
    if (stall_o !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b want 0", stall_o); end
    sb.push_back(bub(1));
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL flush_valid: got %h want %h", o, x); end
    // flushing an empty slot is not counted
    drive(0, I_ADD, 32'h404, 5, 7, 1, 0, 0);
    sb.push_back(bub(1));
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL flush_empty: got %h want %h", o, x); end
    drive(1, I_LW, 32'h200, 32'h1000, 32'h33, 0, 0, 0);
    sb.push_back(lw_exp(1));
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL flush_load: got %h want %h", o, x); end
    drive(1, I_DEP, 32'h204, 9, 7, 1, 0, 0);
    tests++;
    if (stall_o !== 1'b0) begin fails++; $display("FAIL flush_lu_stall: got %b want 0", stall_o); end
    sb.push_back(bub(2));
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL flush_lu: got %h want %h", o, x); end
  endtask

  task automatic test_hold();
    exp_t x, o;
    do_reset();
    drive(1, I_LW, 32'h200, 32'h1000, 32'h33, 0, 0, 0);
    sb.push_back(lw_exp(0));
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL hold_load: got %h want %h", o, x); end
    for (int i = 0; i < 3; i++) begin
      drive(1, I_DEP, 32'h204, 32'(i + 1), 7, i[0], 1, 0);
      tests++;
      if (stall_o !== 1'b1) begin fails++; $display("FAIL hold_stall%0d: got %b want 1", i, stall_o); end
      sb.push_back(lw_exp(0));
      tick();
      x = sb.pop_front(); o = obs(); tests++;
      if (o !== x) begin fails++; $display("FAIL hold_frozen%0d: got %h want %h", i, o, x); end
    end
    drive(1, I_DEP, 32'h204, 9, 7, 0, 0, 0);
    tests++;
    if (stall_o !== 1'b1) begin fails++; $display("FAIL hold_rel_stall: got %b want 1", stall_o); end
    sb.push_back(bub(1));
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL hold_rel_bubble: got %h want %h", o, x); end
  endtask

  task automatic test_illegal();
    exp_t x, o;
    do_reset();
    drive(1, 32'hFC000000, 32'h500, 1, 2, 0, 0, 0);
    x = bub(0); x.valid = 1; x.pc = 32'h500; x.v1 = 1; x.v2 = 2; x.ill = 1;
    sb.push_back(x);
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL ill_opcode: got %h want %h", o, x); end
    drive(1, 32'h00221821, 32'h504, 1, 2, 0, 0, 0);   // funct 0x21 unsupported
    x = bub(0); x.valid = 1; x.pc = 32'h504; x.s1 = 1; x.s2 = 2; x.v1 = 1; x.v2 = 2;
    x.imm = 32'h1821; x.ill = 1;
    sb.push_back(x);
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL ill_funct: got %h want %h", o, x); end
  endtask

  task automatic test_saturate();
    exp_t x, o;
    int want;
    do_reset();
    for (int i = 0; i < (1 << CW) + 4; i++) begin
      drive(1, I_ADD, 32'h600, 1, 1, 1, 0, 0);
      want = (i + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : i + 1;
      sb.push_back(bub(CW'(want)));
      tick();
      x = sb.pop_front(); o = obs(); tests++;
      if (o !== x) begin fails++; $display("FAIL sat%0d: got %h want %h", i, o, x); end
    end
  endtask

  task automatic test_rst_mid_stall();
    exp_t x, o;
    do_reset();
    drive(1, I_LW, 32'h200, 32'h1000, 32'h33, 0, 0, 0);
    tick();
    drive(1, I_DEP, 32'h204, 9, 7, 0, 0, 0);
    tests++;
    if (stall_o !== 1'b1) begin fails++; $display("FAIL rst_pre_stall: got %b want 1", stall_o); end
    tick();   // bubble counted here
    drive(1, I_DEP, 32'h204, 9, 7, 0, 0, 1);
    sb.push_back(bub(0));
    tick();
    x = sb.pop_front(); o = obs(); tests++;
    if (o !== x) begin fails++; $display("FAIL rst_mid: got %h want %h", o, x); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_imm();
    test_flush();
    test_hold();
    test_illegal();
    test_saturate();
    test_rst_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
